// File: rtl/event_encoder_pkg.sv
// Shared defaults and FSM state type for the event encoder slice.
// Imported by the interface, the priority encoder and the top.
package event_encoder_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int CODE_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage : event_encoder_pkg

// File: rtl/event_encoder_if.sv
// Request/code handshake bundle between event sources, consumer and encoder.
// slave = encoder side, master = the environment driving requests and ready.
interface event_encoder_if
  import event_encoder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = CODE_W_DEF
);

  logic [WIDTH-1:0]  req;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic [WIDTH-1:0]  pending;
  logic              drop;

  modport slave (
    input  req,
    input  code_ready,
    output code,
    output code_valid,
    output pending,
    output drop
  );

  modport master (
    output req,
    output code_ready,
    input  code,
    input  code_valid,
    input  pending,
    input  drop
  );

endinterface : event_encoder_if

// File: rtl/event_encoder_pri_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
// Bit 0 has the highest priority so code k always names one-hot bit k.
module pri_encoder
  import event_encoder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [WIDTH-1:0]  i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any
);

  // w_lower[k] is set when any bit below k is set; w_first isolates the winner
  logic [WIDTH:0]   w_lower;
  logic [WIDTH-1:0] w_first;

  assign w_lower[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      assign w_lower[gi+1] = w_lower[gi] | i_vec[gi];
      assign w_first[gi]   = i_vec[gi] & ~w_lower[gi];
    end
  endgenerate

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_first[i]) begin
        o_idx = o_idx | CODE_W'(i);
      end
    end
  end

  assign o_any = w_lower[WIDTH];

endmodule : pri_encoder

// File: rtl/event_encoder.sv
// Captures per-line event requests into a pending set and offers them one code
// per cycle, lowest index first, over a valid/ready handshake.
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  event_encoder_if.slave bus
);

  generate
    if (CODE_W != $clog2(WIDTH)) begin : g_bad_code_w
      $error("event_encoder: CODE_W must equal clog2(WIDTH)");
    end
  endgenerate

  state_e            r_state;
  state_e            w_state_next;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_next;
  logic [WIDTH-1:0]  r_pending;
  logic [WIDTH-1:0]  w_pending_next;
  logic              r_drop;
  logic              w_drop_next;

  logic              w_code_valid;
  logic              w_handshake;
  logic [WIDTH-1:0]  w_served;
  logic [WIDTH-1:0]  w_rem;
  logic [WIDTH-1:0]  w_sel;
  logic [CODE_W-1:0] w_sel_idx;
  logic              w_sel_any;

  assign w_code_valid = (r_state == OFFER);
  assign w_handshake  = w_code_valid & bus.code_ready;
  assign w_served     = w_handshake ? (WIDTH'(1) << r_code) : '0;
  assign w_rem        = r_pending & ~w_served;

  // New requests OR in after clearing, so a same-cycle re-request survives service
  assign w_pending_next = w_rem | bus.req;
  assign w_drop_next    = |(bus.req & w_rem);

  // rem excludes this cycle's requests, so they wait at least one more cycle
  assign w_sel = (r_state == OFFER) ? w_rem : r_pending;

  pri_encoder #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_pri_encoder (
    .i_vec (w_sel),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    case (r_state)
      IDLE: begin
        if (w_sel_any) begin
          w_state_next = OFFER;
          w_code_next  = w_sel_idx;
        end
      end
      OFFER: begin
        // Without a handshake the offer is frozen, even against higher priority
        if (w_handshake) begin
          if (w_sel_any) begin
            w_code_next = w_sel_idx;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_code    <= w_code_next;
      r_pending <= w_pending_next;
      r_drop    <= w_drop_next;
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = w_code_valid;
  assign bus.pending    = r_pending;
  assign bus.drop       = r_drop;

endmodule : event_encoder

// File: tb/tb_event_encoder.sv
// Directed and randomized bench for event_encoder against a set-based model
// of the capture/offer rules; one line per failing comparison plus a summary.
module tb_event_encoder;
  import event_encoder_pkg::*;

  localparam int WIDTH  = 8;
  localparam int CODE_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference state: set of pending event lines and the current offer
  bit       m_pend [WIDTH];
  bit       m_valid;
  int       m_code;
  bit       m_drop;

  event_encoder_if #(.WIDTH(WIDTH), .CODE_W(CODE_W)) bus ();

  event_encoder #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [WIDTH-1:0] pend_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_code  = 0;
    m_drop  = 1'b0;
  endtask

  // Advance the model by one clock given the inputs presented this cycle
  task automatic model_step(input logic [WIDTH-1:0] r, input bit rdy);
    bit np [WIDTH];
    bit hs;
    int served;
    int lowest;
    hs     = m_valid && rdy;
    served = hs ? m_code : -1;
    m_drop = 1'b0;
    lowest = -1;
    for (int i = 0; i < WIDTH; i++) begin
      bit left;
      left  = m_pend[i] && (i != served);
      np[i] = left || r[i];
      if (r[i] && left) m_drop = 1'b1;
      if (left && lowest < 0) lowest = i;
    end
    if (!m_valid) begin
      if (lowest >= 0) begin
        m_valid = 1'b1;
        m_code  = lowest;
      end
    end else if (hs) begin
      if (lowest >= 0) m_code = lowest;
      else m_valid = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) m_pend[i] = np[i];
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.code_valid), 32'(m_valid));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(pend_vec()));
    chk({tag, ".drop"}, 32'(bus.drop), 32'(m_drop));
    if (m_valid) chk({tag, ".code"}, 32'(bus.code), 32'(m_code));
  endtask

  // Present inputs for one cycle, clock, then compare just after the edge
  task automatic step(input string tag, input logic [WIDTH-1:0] r, input bit rdy);
    bus.req        = r;
    bus.code_ready = rdy;
    model_step(r, rdy);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    bus.req        = '0;
    bus.code_ready = 1'b0;
    model_reset();

    // Requests during reset are ignored
    #2;
    bus.req = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pending", 32'(bus.pending), 32'h0);
    chk("rst.valid", 32'(bus.code_valid), 32'h0);
    chk("rst.code", 32'(bus.code), 32'h0);
    chk("rst.drop", 32'(bus.drop), 32'h0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all("rst.release");

    // Single request: latency and return to idle
    step("t28.a", 8'b0000_0100, 1'b1);
    chk("t28.a.valid_late", 32'(bus.code_valid), 32'h0);
    step("t28.b", 8'h00, 1'b1);
    chk("t28.b.code2", 32'(bus.code), 32'd2);
    step("t28.c", 8'h00, 1'b1);
    chk("t28.c.idle", 32'(bus.code_valid), 32'h0);

    // Two lines: codes 0 then 7 back to back
    step("t29.a", 8'b1000_0001, 1'b1);
    step("t29.b", 8'h00, 1'b1);
    chk("t29.b.code0", 32'(bus.code), 32'd0);
    step("t29.c", 8'h00, 1'b1);
    chk("t29.c.code7", 32'(bus.code), 32'd7);
    step("t29.d", 8'h00, 1'b1);
    chk("t29.d.idle", 32'(bus.code_valid), 32'h0);

    // Offer holds against a higher-priority arrival
    step("t30.a", 8'b0010_0000, 1'b0);
    step("t30.b", 8'h00, 1'b0);
    step("t30.c", 8'b0000_0010, 1'b0);
    chk("t30.c.hold5", 32'(bus.code), 32'd5);
    step("t30.d", 8'h00, 1'b0);
    chk("t30.d.hold5", 32'(bus.code), 32'd5);
    step("t30.e", 8'h00, 1'b1);
    chk("t30.e.code1", 32'(bus.code), 32'd1);
    step("t30.f", 8'h00, 1'b1);

    // Re-request on an unserved pending line merges and drops once
    step("t31.a", 8'b0000_1000, 1'b0);
    step("t31.b", 8'b0000_1000, 1'b0);
    chk("t31.b.drop", 32'(bus.drop), 32'h1);
    step("t31.c", 8'h00, 1'b0);
    chk("t31.c.drop_clear", 32'(bus.drop), 32'h0);
    step("t31.d", 8'h00, 1'b1);
    chk("t31.d.once", 32'(bus.code_valid), 32'h0);
    step("t31.e", 8'h00, 1'b1);

    // Re-request on the line being served wins and re-offers
    step("t32.a", 8'b0001_0000, 1'b0);
    step("t32.b", 8'h00, 1'b1);
    chk("t32.b.code4", 32'(bus.code), 32'd4);
    step("t32.c", 8'b0001_0000, 1'b1);
    chk("t32.c.nodrop", 32'(bus.drop), 32'h0);
    chk("t32.c.kept", 32'(bus.pending), 32'h10);
    step("t32.d", 8'h00, 1'b1);
    chk("t32.d.code4", 32'(bus.code), 32'd4);
    step("t32.e", 8'h00, 1'b1);

    // Asynchronous reset in the middle of an offer
    step("t33.a", 8'hFF, 1'b0);
    step("t33.b", 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t33.async.valid", 32'(bus.code_valid), 32'h0);
    chk("t33.async.pending", 32'(bus.pending), 32'h0);
    chk("t33.async.code", 32'(bus.code), 32'h0);
    chk("t33.async.drop", 32'(bus.drop), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("t33.quiet", 8'h00, 1'b1);

    // Randomized traffic with sparse requests
    for (int k = 0; k < 400; k++) begin
      logic [WIDTH-1:0] r;
      bit rdy;
      r   = WIDTH'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      step("rnd", r, rdy);
    end
    for (int k = 0; k < 10; k++) step("drain", 8'h00, 1'b1);
    chk("drain.idle", 32'(bus.code_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_event_encoder
